// File: rtl/v_upd_arb_if.sv
// Shared payload types and the requester/update bus bundle for the v update arbiter.
// Latency: n/a (type and wiring definitions only).
// Backpressure: o_req_rdy is the per-requester grant; a transfer happens on vld & rdy.
package v_pkg;
    typedef logic [7:0]  id_t;
    typedef logic [1:0]  cmd_t;
    typedef logic [15:0] key_t;
    typedef logic [7:0]  size_t;
endpackage

interface v_upd_arb_if #(
    parameter int REQ_N = 4
);
    localparam int SRC_W = $clog2(REQ_N);

    logic [REQ_N-1:0]               i_req_vld;
    v_pkg::id_t   [REQ_N-1:0]       i_req_prod_id;
    v_pkg::cmd_t  [REQ_N-1:0]       i_req_cmd;
    v_pkg::key_t  [REQ_N-1:0]       i_req_key;
    v_pkg::size_t [REQ_N-1:0]       i_req_size;
    logic [REQ_N-1:0]               o_req_rdy;
    logic                           i_busy;
    logic                           i_flush;
    logic                           o_upd_vld_r;
    v_pkg::id_t                     o_upd_prod_id_r;
    v_pkg::cmd_t                    o_upd_cmd_r;
    v_pkg::key_t                    o_upd_key_r;
    v_pkg::size_t                   o_upd_size_r;
    logic [SRC_W-1:0]               o_upd_src_r;
    logic                           o_flushed_r;
    logic [15:0]                    o_stall_cnt_r;

    modport master (
        output i_req_vld, i_req_prod_id, i_req_cmd, i_req_key, i_req_size, i_busy, i_flush,
        input  o_req_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r,
               o_upd_size_r, o_upd_src_r, o_flushed_r, o_stall_cnt_r
    );

    modport slave (
        input  i_req_vld, i_req_prod_id, i_req_cmd, i_req_key, i_req_size, i_busy, i_flush,
        output o_req_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r,
               o_upd_size_r, o_upd_src_r, o_flushed_r, o_stall_cnt_r
    );
endinterface

// File: rtl/v_upd_arb.sv
// Round-robin arbiter feeding the v update pipeline, blocking same-product updates in flight.
// Latency: grant in cycle t appears on the registered o_upd bus in cycle t+1.
// Backpressure: combinational o_req_rdy; withheld on busy, flush, hazard, or outside RUN.
module v_upd_arb #(
    parameter int REQ_N        = 4,
    parameter int HAZARD_DEPTH = 5
) (
    input  logic       clk,
    input  logic       arst_n,
    v_upd_arb_if.slave bus
);
    localparam int SRC_W = $clog2(REQ_N);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]              state_r;
    logic [1:0]              state_nxt;
    logic [SRC_W-1:0]        ptr_r;
    logic [HAZARD_DEPTH-1:0] win_vld_r;
    v_pkg::id_t              win_id_r [HAZARD_DEPTH];
    logic                    issue_ok;
    logic [REQ_N-1:0]        elig;
    logic [REQ_N-1:0]        grant;
    logic                    grant_any;
    logic [SRC_W-1:0]        cand;
    logic [SRC_W-1:0]        win_idx;
    logic                    stall;
    logic                    flushed_r;
    v_pkg::cmd_t             cmd_r;
    v_pkg::key_t             key_r;
    v_pkg::size_t            size_r;
    logic [SRC_W-1:0]        src_r;
    logic [15:0]             stall_cnt_r;

    // Grants only in RUN with the pipeline idle-able and no flush pending; reset forces rdy low.
    assign issue_ok = arst_n && (state_r == ST_RUN) && !bus.i_busy && !bus.i_flush;

    // A requester is eligible unless its product is still somewhere in the hazard window.
    always_comb begin
        elig = '0;
        for (int i = 0; i < REQ_N; i++) begin
            elig[i] = issue_ok && bus.i_req_vld[i];
            for (int k = 0; k < HAZARD_DEPTH; k++) begin
                if (win_vld_r[k] && (win_id_r[k] == bus.i_req_prod_id[i])) begin
                    elig[i] = 1'b0;
                end
            end
        end
    end

    // Round-robin pick starting just after the last winner; ineligible requesters are skipped.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        win_idx   = ptr_r;
        cand      = '0;
        for (int k = 1; k <= REQ_N; k++) begin
            cand = ptr_r + SRC_W'(k);
            if (!grant_any && elig[cand]) begin
                grant_any = 1'b1;
                win_idx   = cand;
            end
        end
        if (grant_any) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign bus.o_req_rdy = grant;

    // Next-state logic. DRAIN exits on the edge that shifts out the last valid window entry,
    // so DONE (and o_flushed_r) coincide with an empty window.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_BOOT:  if (!bus.i_busy)                        state_nxt = ST_RUN;
            ST_RUN:   if (bus.i_flush)                        state_nxt = ST_DRAIN;
            ST_DRAIN: if (~|win_vld_r[HAZARD_DEPTH-2:0])      state_nxt = ST_DONE;
            ST_DONE:  if (!bus.i_flush)                       state_nxt = ST_RUN;
            default:                                          state_nxt = ST_BOOT;
        endcase
    end

    // FSM state, round-robin pointer and the drain-complete flag.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_r   <= ST_BOOT;
            ptr_r     <= SRC_W'(REQ_N - 1);
            flushed_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            flushed_r <= (state_nxt == ST_DONE);
            if (grant_any) begin
                ptr_r <= win_idx;
            end
        end
    end

    // Hazard window: entry 0 is the live o_upd bus; shifts every cycle, bubble on no grant.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            win_vld_r <= '0;
            for (int k = 0; k < HAZARD_DEPTH; k++) begin
                win_id_r[k] <= '0;
            end
        end else begin
            win_vld_r <= {win_vld_r[HAZARD_DEPTH-2:0], grant_any};
            if (grant_any) begin
                win_id_r[0] <= bus.i_req_prod_id[win_idx];
            end
            for (int k = 1; k < HAZARD_DEPTH; k++) begin
                win_id_r[k] <= win_id_r[k-1];
            end
        end
    end

    // Payload and source registers load on a grant and hold otherwise.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cmd_r  <= '0;
            key_r  <= '0;
            size_r <= '0;
            src_r  <= '0;
        end else if (grant_any) begin
            cmd_r  <= bus.i_req_cmd[win_idx];
            key_r  <= bus.i_req_key[win_idx];
            size_r <= bus.i_req_size[win_idx];
            src_r  <= win_idx;
        end
    end

    assign stall = (state_r == ST_RUN) && !bus.i_busy && (|bus.i_req_vld) && !grant_any;

    // Saturating count of cycles where someone wanted to issue in RUN but nobody was granted.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cnt_r <= '0;
        end else if (stall && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign bus.o_upd_vld_r     = win_vld_r[0];
    assign bus.o_upd_prod_id_r = win_id_r[0];
    assign bus.o_upd_cmd_r     = cmd_r;
    assign bus.o_upd_key_r     = key_r;
    assign bus.o_upd_size_r    = size_r;
    assign bus.o_upd_src_r     = src_r;
    assign bus.o_flushed_r     = flushed_r;
    assign bus.o_stall_cnt_r   = stall_cnt_r;
endmodule
